sdr_ch_arbiter: RTL and testbench

SDR_CH_ARBITER -- requirements
Module: sdr_ch_arbiter

---
 rtl/system_consts.sv | 26 ++
 rtl/sdr_prio_select.sv | 33 +++
 rtl/sdr_ch_arbiter.sv | 153 +++++++++++++++
 tb/tb_sdr_ch_arbiter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/system_consts.sv
// Shared SDRAM interface widths, channel naming and arbiter state encoding.
package system_consts;

    localparam int unsigned SDR_AW  = 27;
    localparam int unsigned SDR_DW  = 64;
    localparam int unsigned SDR_BEW = 8;

    typedef enum logic [2:0] {
        CH_SCN0    = 3'd0,
        CH_SCN_MUX = 3'd1,
        CH_AUDIO   = 3'd2,
        CH_CPU     = 3'd3,
        CH_ROM     = 3'd4
    } ch_idx_e;

    typedef enum logic [1:0] {
        StSync   = 2'd0,
        StIdle   = 2'd1,
        StActive = 2'd2
    } arb_state_e;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sdr_prio_select.sv
// Combinational winner pick: lowest-index starved request, else lowest-index pending request.
module sdr_prio_select
    import system_consts::*;
#(
    parameter int unsigned NUM_CH = 5,
    parameter int unsigned IDX_W  = idx_width(NUM_CH)
) (
    input  logic [NUM_CH-1:0] i_pending,
    input  logic [NUM_CH-1:0] i_starved,
    output logic [NUM_CH-1:0] o_onehot,
    output logic [IDX_W-1:0]  o_idx,
    output logic              o_valid
);

    logic [NUM_CH-1:0] w_cand;

    always_comb begin
        w_cand   = ((i_starved & i_pending) != '0) ? (i_starved & i_pending) : i_pending;
        o_onehot = '0;
        o_idx    = '0;
        // Scan downwards so the lowest set index is the last one written.
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (w_cand[i]) begin
                o_onehot    = '0;
                o_onehot[i] = 1'b1;
                o_idx       = IDX_W'(i);
            end
        end
    end

    assign o_valid = |i_pending;

endmodule

// File: rtl/sdr_ch_arbiter.sv
// Multi-channel toggle-handshake arbiter in front of a single SDRAM controller port,
// with fixed priority plus starvation promotion.
module sdr_ch_arbiter
    import system_consts::*;
#(
    parameter int unsigned NUM_CH       = 5,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_CH-1:0]                ch_req,
    output logic [NUM_CH-1:0]                ch_ack,
    input  logic [NUM_CH-1:0][SDR_AW-1:0]    ch_addr,
    input  logic [NUM_CH-1:0]                ch_rw,
    input  logic [NUM_CH-1:0][SDR_DW-1:0]    ch_data,
    input  logic [NUM_CH-1:0][SDR_BEW-1:0]   ch_be,
    output logic [NUM_CH-1:0][SDR_DW-1:0]    ch_q,
    output logic [SDR_AW-1:0]                sdr_addr,
    output logic [SDR_DW-1:0]                sdr_data,
    output logic [SDR_BEW-1:0]               sdr_be,
    output logic                             sdr_rw,
    output logic                             sdr_req,
    input  logic                             sdr_ack,
    input  logic [SDR_DW-1:0]                sdr_q,
    output logic                             busy
);

    localparam int unsigned AGE_W   = $clog2(STARVE_LIMIT + 1);
    localparam int unsigned IDX_W   = idx_width(NUM_CH);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(STARVE_LIMIT);

    arb_state_e                         r_state;
    arb_state_e                         w_state_next;
    logic [NUM_CH-1:0]                  r_ch_ack;
    logic [NUM_CH-1:0][AGE_W-1:0]       r_age;
    logic [NUM_CH-1:0][AGE_W-1:0]       w_age_next;
    logic [IDX_W-1:0]                   r_grant;
    logic                               r_req_snap;
    logic [SDR_AW-1:0]                  r_sdr_addr;
    logic [SDR_DW-1:0]                  r_sdr_data;
    logic [SDR_BEW-1:0]                 r_sdr_be;
    logic                               r_sdr_rw;
    logic                               r_sdr_req;
    logic [NUM_CH-1:0][SDR_DW-1:0]      r_ch_q;

    logic [NUM_CH-1:0]                  w_pending;
    logic [NUM_CH-1:0]                  w_starved;
    logic [NUM_CH-1:0]                  w_sel_onehot;
    logic [IDX_W-1:0]                   w_sel_idx;
    logic                               w_sel_valid;
    logic                               w_issue;
    logic                               w_complete;

    assign w_pending = ch_req ^ r_ch_ack;

    sdr_prio_select #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W)
    ) u_prio_select (
        .i_pending (w_pending),
        .i_starved (w_starved),
        .o_onehot  (w_sel_onehot),
        .o_idx     (w_sel_idx),
        .o_valid   (w_sel_valid)
    );

    always_comb begin
        w_state_next = r_state;
        w_issue      = 1'b0;
        w_complete   = 1'b0;
        case (r_state)
            StSync: begin
                if (sdr_ack == r_sdr_req) begin
                    w_state_next = StIdle;
                end
            end
            StIdle: begin
                if (w_sel_valid) begin
                    w_issue      = 1'b1;
                    w_state_next = StActive;
                end
            end
            StActive: begin
                if (sdr_ack == r_sdr_req) begin
                    w_complete   = 1'b1;
                    w_state_next = StIdle;
                end
            end
            default: begin
                w_state_next = StSync;
            end
        endcase
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            w_age_next[i] = r_age[i];
            w_starved[i]  = (r_age[i] == AGE_MAX);
            if (w_issue) begin
                if (w_sel_onehot[i] || !w_pending[i]) begin
                    w_age_next[i] = '0;
                end else if (r_age[i] != AGE_MAX) begin
                    w_age_next[i] = r_age[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= StSync;
            r_ch_ack   <= '0;
            r_age      <= '0;
            r_grant    <= '0;
            r_req_snap <= 1'b0;
            r_sdr_addr <= '0;
            r_sdr_data <= '0;
            r_sdr_be   <= '0;
            r_sdr_rw   <= 1'b1;
            r_sdr_req  <= 1'b0;
            r_ch_q     <= '0;
        end else begin
            r_state <= w_state_next;
            r_age   <= w_age_next;
            if (w_issue) begin
                r_grant    <= w_sel_idx;
                r_req_snap <= ch_req[w_sel_idx];
                r_sdr_addr <= ch_addr[w_sel_idx];
                r_sdr_data <= ch_data[w_sel_idx];
                r_sdr_be   <= ch_be[w_sel_idx];
                r_sdr_rw   <= ch_rw[w_sel_idx];
                r_sdr_req  <= ~r_sdr_req;
            end
            if (w_complete) begin
                // Ack the request level seen at grant; a re-toggle during the transfer stays pending.
                r_ch_ack[r_grant] <= r_req_snap;
                if (r_sdr_rw) begin
                    r_ch_q[r_grant] <= sdr_q;
                end
            end
        end
    end

    assign ch_ack   = r_ch_ack;
    assign ch_q     = r_ch_q;
    assign sdr_addr = r_sdr_addr;
    assign sdr_data = r_sdr_data;
    assign sdr_be   = r_sdr_be;
    assign sdr_rw   = r_sdr_rw;
    assign sdr_req  = r_sdr_req;
    assign busy     = (r_state != StIdle);

endmodule

// File: tb/tb_sdr_ch_arbiter.sv
// Directed and randomized bench for sdr_ch_arbiter against a transaction-level arbitration model.
module tb_sdr_ch_arbiter;

    localparam int NCH   = 5;
    localparam int LIMIT = 8;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NCH-1:0]        ch_req;
    logic [NCH-1:0]        ch_ack;
    logic [NCH-1:0][26:0]  ch_addr;
    logic [NCH-1:0]        ch_rw;
    logic [NCH-1:0][63:0]  ch_data;
    logic [NCH-1:0][7:0]   ch_be;
    logic [NCH-1:0][63:0]  ch_q;
    logic [26:0]           sdr_addr;
    logic [63:0]           sdr_data;
    logic [7:0]            sdr_be;
    logic                  sdr_rw;
    logic                  sdr_req;
    logic                  sdr_ack;
    logic [63:0]           sdr_q;
    logic                  busy;

    sdr_ch_arbiter #(
        .NUM_CH       (NCH),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .ch_req   (ch_req),
        .ch_ack   (ch_ack),
        .ch_addr  (ch_addr),
        .ch_rw    (ch_rw),
        .ch_data  (ch_data),
        .ch_be    (ch_be),
        .ch_q     (ch_q),
        .sdr_addr (sdr_addr),
        .sdr_data (sdr_data),
        .sdr_be   (sdr_be),
        .sdr_rw   (sdr_rw),
        .sdr_req  (sdr_req),
        .sdr_ack  (sdr_ack),
        .sdr_q    (sdr_q),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    logic [NCH-1:0] m_ack;
    int             m_age [NCH];
    logic           m_sdr_req;
    logic [26:0]    m_addr;
    logic [63:0]    m_data;
    logic [7:0]     m_be;
    logic           m_rw;
    logic [63:0]    m_q [NCH];
    int             g;
    logic           snap;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ack     = '0;
        m_sdr_req = 1'b0;
        m_addr    = '0;
        m_data    = '0;
        m_be      = '0;
        m_rw      = 1'b1;
        for (int i = 0; i < NCH; i++) begin
            m_age[i] = 0;
            m_q[i]   = '0;
        end
    endtask

    function automatic bit pend(input int i);
        return ch_req[i] != m_ack[i];
    endfunction

    // Starved requesters first (lowest index), then plain fixed priority.
    function automatic int winner();
        for (int i = 0; i < NCH; i++) if (pend(i) && m_age[i] >= LIMIT) return i;
        for (int i = 0; i < NCH; i++) if (pend(i)) return i;
        return -1;
    endfunction

    task automatic post(input int i, input logic [26:0] a, input logic rw,
                        input logic [63:0] d, input logic [7:0] be);
        ch_addr[i] = a;
        ch_rw[i]   = rw;
        ch_data[i] = d;
        ch_be[i]   = be;
        ch_req[i]  = ~ch_req[i];
    endtask

    task automatic expect_issue(output int w);
        w = winner();
        if (w < 0) begin
            $display("FAIL model_pending: observed none expected at least one");
            $fatal(1, "bench sequencing error");
        end
        m_addr = ch_addr[w];
        m_rw   = ch_rw[w];
        m_data = ch_data[w];
        m_be   = ch_be[w];
        snap   = ch_req[w];
        for (int i = 0; i < NCH; i++) begin
            if (i == w || !pend(i)) m_age[i] = 0;
            else if (m_age[i] < LIMIT) m_age[i] = m_age[i] + 1;
        end
        g = w;
        tick();
        m_sdr_req = ~m_sdr_req;
        chk("issue_sdr_req", sdr_req, m_sdr_req);
        chk("issue_busy", busy, 1);
        chk("issue_addr", sdr_addr, m_addr);
        chk("issue_rw", sdr_rw, m_rw);
        chk("issue_data", sdr_data, m_data);
        chk("issue_be", sdr_be, m_be);
        chk("issue_ch_ack", ch_ack, m_ack);
    endtask

    task automatic complete(input int dly, input logic [63:0] q);
        for (int k = 1; k < dly; k++) begin
            tick();
            chk("active_busy", busy, 1);
            chk("active_ch_ack", ch_ack, m_ack);
            chk("active_data_hold", sdr_data, m_data);
        end
        sdr_q   = q;
        sdr_ack = m_sdr_req;
        tick();
        sdr_q = ~q;
        m_ack[g] = snap;
        if (m_rw) m_q[g] = q;
        chk("done_ch_ack", ch_ack, m_ack);
        chk("done_ch_q", ch_q[g], m_q[g]);
        chk("done_busy", busy, 0);
        chk("done_sdr_req", sdr_req, m_sdr_req);
        chk("done_addr_hold", sdr_addr, m_addr);
    endtask

    initial begin
        int w;
        int n_issue;
        int ch4_at;

        reset   = 1'b1;
        ch_req  = '0;
        ch_addr = '0;
        ch_rw   = '1;
        ch_data = '0;
        ch_be   = '0;
        sdr_ack = 1'b1;
        sdr_q   = '0;
        model_reset();

        // Reset values, then SYNC held while the controller ack disagrees
        tick();
        tick();
        chk("rst_ch_ack", ch_ack, 0);
        chk("rst_sdr_req", sdr_req, 0);
        chk("rst_sdr_rw", sdr_rw, 1);
        chk("rst_sdr_addr", sdr_addr, 0);
        chk("rst_sdr_data", sdr_data, 0);
        chk("rst_sdr_be", sdr_be, 0);
        chk("rst_ch_q3", ch_q[3], 0);
        chk("rst_busy", busy, 1);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("sync_no_req", sdr_req, 0);
            chk("sync_busy", busy, 1);
        end
        sdr_ack = 1'b0;
        tick();
        chk("sync_to_idle", busy, 0);

        // Channel 3 read with a 4-cycle controller response
        post(3, 27'h0123450, 1'b1, 64'h0, 8'h00);
        expect_issue(w);
        complete(4, 64'hDEADBEEF_CAFEF00D);
        chk("ch3_q_value", ch_q[3], 64'hDEADBEEF_CAFEF00D);

        // Idle with nothing pending holds the controller side
        tick();
        tick();
        chk("idle_hold_req", sdr_req, m_sdr_req);
        chk("idle_hold_addr", sdr_addr, m_addr);
        chk("idle_busy", busy, 0);

        // Channels 0 and 4 together: 0 first, 4 after one idle cycle
        post(0, 27'h0000100, 1'b1, 64'h0, 8'h00);
        post(4, 27'h0000400, 1'b1, 64'h0, 8'h00);
        expect_issue(w);
        complete(2, 64'h1111_2222_3333_4444);
        expect_issue(w);
        complete(3, 64'h5555_6666_7777_8888);

        // Channel 4 write; payload and request re-toggled mid-transfer
        post(4, 27'h0000440, 1'b0, 64'h00000000_0000A55A, 8'h03);
        expect_issue(w);
        chk("wr_rw", sdr_rw, 0);
        chk("wr_data", sdr_data, 64'h00000000_0000A55A);
        chk("wr_be", sdr_be, 8'h03);
        post(4, 27'h0000480, 1'b1, 64'hFFFF_0000_FFFF_0000, 8'hF0);
        complete(3, 64'h0BAD_0BAD_0BAD_0BAD);
        chk("wr_ch_q4_kept", ch_q[4], 64'h5555_6666_7777_8888);
        expect_issue(w);
        complete(1, 64'h0123_4567_89AB_CDEF);

        // Starvation: ch0 keeps re-requesting while ch4 waits
        post(4, 27'h0000500, 1'b1, 64'h0, 8'h00);
        ch4_at  = -1;
        n_issue = 0;
        for (int k = 0; k < 12 && ch4_at < 0; k++) begin
            if (!pend(0)) post(0, 27'h0000000 + 27'(k), 1'b1, 64'h0, 8'h00);
            expect_issue(w);
            n_issue++;
            if (w == 4) ch4_at = n_issue;
            complete(1, {$urandom, $urandom});
        end
        chk("starve_issue_no", ch4_at, LIMIT + 1);
        if (pend(0)) begin
            expect_issue(w);
            complete(1, {$urandom, $urandom});
        end

        // Reset in the middle of a channel 2 transfer
        reset   = 1'b1;
        ch_req  = '0;
        sdr_ack = 1'b0;
        tick();
        reset = 1'b0;
        model_reset();
        tick();
        post(2, 27'h0000222, 1'b1, 64'h0, 8'h00);
        expect_issue(w);
        tick();
        reset     = 1'b1;
        ch_req[2] = 1'b0;
        tick();
        reset = 1'b0;
        model_reset();
        sdr_ack = 1'b1;
        tick();
        chk("abort_ch_ack2", ch_ack[2], 0);
        chk("abort_busy", busy, 1);
        post(2, 27'h0000222, 1'b1, 64'h0, 8'h00);
        tick();
        chk("abort_sync_hold", sdr_req, 0);
        chk("abort_sync_busy", busy, 1);
        sdr_ack = 1'b0;
        tick();
        chk("abort_resync", busy, 0);
        expect_issue(w);
        complete(2, 64'h2222_2222_2222_2222);

        // Randomized traffic
        for (int t = 0; t < 60; t++) begin
            for (int i = 0; i < NCH; i++) begin
                if (!pend(i) && $urandom_range(0, 2) == 0)
                    post(i, 27'($urandom), 1'($urandom), {$urandom, $urandom}, 8'($urandom));
            end
            if (winner() < 0) begin
                w = int'($urandom_range(0, NCH - 1));
                post(w, 27'($urandom), 1'($urandom), {$urandom, $urandom}, 8'($urandom));
            end
            expect_issue(w);
            if ($urandom_range(0, 3) == 0)
                post(w, 27'($urandom), 1'($urandom), {$urandom, $urandom}, 8'($urandom));
            complete(int'($urandom_range(1, 4)), {$urandom, $urandom});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
